// File: rtl/fetch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter states,
// default table depth and reset fetch address, plus the saturating counter step.
package fetch_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int unsigned ENTRIES_DEFAULT  = 16;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target table with 2-bit direction counters.
// Lookup is combinational; updates land on the clock edge, so same-cycle lookups see old contents.
module btb_table
  import fetch_predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_lookup_word,
  output logic        o_pred,
  output logic [31:0] o_target,
  input  logic        i_upd_en,
  input  logic [29:0] i_upd_word,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic            r_valid  [ENTRIES];
  logic [TW-1:0]   r_tag    [ENTRIES];
  logic [31:0]     r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];

  logic [IW-1:0]   w_lk_idx;
  logic [TW-1:0]   w_lk_tag;
  logic [IW-1:0]   w_up_idx;
  logic [TW-1:0]   w_up_tag;
  logic            w_lk_hit;
  logic            w_up_hit;
  logic            w_write;

  assign w_lk_idx = i_lookup_word[IW-1:0];
  assign w_lk_tag = i_lookup_word[29:IW];
  assign w_up_idx = i_upd_word[IW-1:0];
  assign w_up_tag = i_upd_word[29:IW];

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_pred   = w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_target = r_target[w_lk_idx];

  // Hits always retrain; misses allocate only when taken, never when not-taken.
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_write  = !rst && i_upd_en && (w_up_hit || i_upd_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (w_write) begin
      r_valid[w_up_idx] <= 1'b1;
      r_ctr[w_up_idx]   <= w_up_hit ? ctr_step(r_ctr[w_up_idx], i_upd_taken) : CTR_WT;
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= i_upd_target;
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC sequencer: chooses next fetch address from reset, EX-stage redirect,
// stall, predicted-taken target or sequential PC, and counts branches and mispredictions.
module fetch_predictor
  import fetch_predictor_pkg::*;
#(
  parameter int          ENTRIES  = ENTRIES_DEFAULT,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  output logic [31:0] pc_f,
  output logic        br_pred_f,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred,
  output logic        mispredict,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_br_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] w_pc_next;
  logic [31:0] w_pred_target;
  logic        w_pred;
  logic        w_ex_br;

  assign w_ex_br    = ex_valid && ex_is_br;
  assign mispredict = w_ex_br && (ex_pred != ex_taken);

  btb_table #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_word (r_pc[31:2]),
    .o_pred        (w_pred),
    .o_target      (w_pred_target),
    .i_upd_en      (w_ex_br),
    .i_upd_word    (ex_pc[31:2]),
    .i_upd_taken   (ex_taken),
    .i_upd_target  (ex_target)
  );

  // A redirect from EX outranks a stall so the wrong path is dropped immediately.
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (mispredict) begin
      w_pc_next = ex_taken ? ex_target : ex_pc + 32'd4;
    end else if (stall_f) begin
      w_pc_next = r_pc;
    end else if (w_pred) begin
      w_pc_next = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
      if (w_ex_br) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (mispredict) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign pc_f      = r_pc;
  assign br_pred_f = w_pred;
  assign br_cnt    = r_br_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_fetch_predictor.sv
// Randomized plus directed bench for fetch_predictor against a behavioural
// model of the predictor table and fetch sequencing.
module tb_fetch_predictor;

  localparam int          ENTRIES  = 16;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic [31:0] pc_f;
  logic        br_pred_f;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred;
  logic        mispredict;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_br;
  logic [31:0] m_miss;
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  fetch_predictor #(
    .ENTRIES  (ENTRIES),
    .PC_RESET (PC_RESET)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_f    (stall_f),
    .pc_f       (pc_f),
    .br_pred_f  (br_pred_f),
    .ex_valid   (ex_valid),
    .ex_is_br   (ex_is_br),
    .ex_pc      (ex_pc),
    .ex_taken   (ex_taken),
    .ex_target  (ex_target),
    .ex_pred    (ex_pred),
    .mispredict (mispredict),
    .br_cnt     (br_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_predict(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  // One clock: drive inputs at negedge, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst_i, input bit stall_i, input bit exv, input bit exbr,
                       input logic [31:0] expc, input bit tk, input logic [31:0] tgt, input bit pr);
    bit mp;
    bit pred;
    int i;
    @(negedge clk);
    rst = rst_i; stall_f = stall_i; ex_valid = exv; ex_is_br = exbr;
    ex_pc = expc; ex_taken = tk; ex_target = tgt; ex_pred = pr;
    #1;
    mp = exv && exbr && (pr != tk);
    if (m_known) begin
      check_eq("pc_f", pc_f, m_pc);
      check_eq("br_pred_f", {31'd0, br_pred_f}, {31'd0, m_predict(m_pc)});
      check_eq("mispredict", {31'd0, mispredict}, {31'd0, mp});
      check_eq("br_cnt", br_cnt, m_br);
      check_eq("miss_cnt", miss_cnt, m_miss);
    end
    $display("t=%0t rst=%0b stall=%0b ex=%0b%0b pc=%h tk=%0b tgt=%h pr=%0b | pc_f=%h pred=%0b mp=%0b",
             $time, rst_i, stall_i, exv, exbr, expc, tk, tgt, pr, pc_f, br_pred_f, mispredict);
    @(posedge clk);
    if (rst_i) begin
      m_pc = PC_RESET; m_br = 0; m_miss = 0; m_known = 1'b1;
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (m_known) begin
      pred = m_predict(m_pc);
      if (mp)           m_pc = tk ? tgt : expc + 32'd4;
      else if (stall_i) m_pc = m_pc;
      else if (pred)    m_pc = m_target[m_idx(m_pc)];
      else              m_pc = m_pc + 32'd4;
      if (exv && exbr) begin
        m_br = m_br + 1;
        i = m_idx(expc);
        if (m_hit(expc)) begin
          m_ctr[i]    = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          m_target[i] = tgt;
        end else if (tk) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = m_tagof(expc);
          m_target[i] = tgt;
          m_ctr[i]    = 2;
        end
      end
      if (mp) m_miss = m_miss + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rpc;
    logic [31:0] rtgt;
    rst = 1'b1; stall_f = 0; ex_valid = 0; ex_is_br = 0;
    ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pred = 0;

    // Reset then sequential fetch
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    #2;
    check_eq("reset_pc", pc_f, 32'h3000);
    check_eq("reset_pred", {31'd0, br_pred_f}, 32'd0);
    check_eq("reset_brcnt", br_cnt, 32'd0);
    idle(3);
    #2 check_eq("seq_pc", pc_f, 32'h300C);

    // Taken branch unknown to table: redirect and allocate
    cycle(0, 0, 1, 1, 32'h3010, 1, 32'h3040, 0);
    #2;
    check_eq("alloc_redirect", pc_f, 32'h3040);
    check_eq("alloc_miss_cnt", miss_cnt, 32'd1);

    // Steer fetch back to 3010 via a not-taken redirect from 300C
    cycle(0, 0, 1, 1, 32'h300C, 0, 32'h0, 1);
    #2;
    check_eq("steer_pc", pc_f, 32'h3010);
    check_eq("hit_pred_wt", {31'd0, br_pred_f}, 32'd1);
    idle(1);
    #2 check_eq("pred_follow", pc_f, 32'h3040);

    cycle(0, 0, 1, 1, 32'h3010, 1, 32'h3040, 1);
    cycle(0, 0, 1, 1, 32'h3010, 0, 32'h3040, 1);
    #2 check_eq("nt_redirect", pc_f, 32'h3014);
    cycle(0, 0, 1, 1, 32'h3010, 0, 32'h3040, 0);
    cycle(0, 0, 1, 1, 32'h300C, 0, 32'h0, 1);
    #2;
    check_eq("wnt_pc", pc_f, 32'h3010);
    check_eq("wnt_pred", {31'd0, br_pred_f}, 32'd0);

    // Mispredict overrides stall; plain stall holds
    cycle(0, 1, 1, 1, 32'h3050, 1, 32'h3080, 0);
    #2 check_eq("stall_redirect", pc_f, 32'h3080);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    #2 check_eq("stall_hold", pc_f, 32'h3080);

    // Reset dominates a mispredicting branch
    cycle(1, 0, 1, 1, 32'h3010, 1, 32'h3090, 0);
    #2;
    check_eq("rst_dom_pc", pc_f, 32'h3000);
    check_eq("rst_dom_brcnt", br_cnt, 32'd0);
    check_eq("rst_dom_miss", miss_cnt, 32'd0);
    idle(4);
    #2;
    check_eq("rst_table_pc", pc_f, 32'h3010);
    check_eq("rst_table_pred", {31'd0, br_pred_f}, 32'd0);

    // Sequential address wraps at the top of the address space
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
    #2 check_eq("wrap_pc", pc_f, 32'h0000_0000);
    idle(1);

    // Randomized traffic around a small code region
    for (int n = 0; n < 3000; n++) begin
      rpc  = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
      rtgt = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
            rpc, ($urandom_range(0, 1) == 1), rtgt, ($urandom_range(0, 1) == 1));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
